// File: rtl/ring_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ring_buffer_pkg
// Description : Shared types and defaults for the convolution input ring
//               buffer and its read-side consumer (ring_buffer_reader).
//               Contents:
//                 DEF_DATA_WIDTH / DEF_DATA_OF_SET - default word/set sizes
//                 data_set_t      - one buffer entry (lane-indexed words)
//                 reader_state_t  - reader FSM encoding
//                 lane_width()    - lane index width for a given set size
// Revision    : 1.0 - initial release
// ============================================================================
package ring_buffer_pkg;

  localparam int DEF_DATA_WIDTH  = 4;
  localparam int DEF_DATA_OF_SET = 4;

  // One buffer entry: element [i] is lane i.
  typedef logic [DEF_DATA_OF_SET-1:0][DEF_DATA_WIDTH-1:0] data_set_t;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_WAIT = 2'd1,
    RS_SEND = 2'd2
  } reader_state_t;

  // Lane index width; a set always has at least two lanes, so this is >= 1.
  function automatic int lane_width(input int data_of_set);
    return (data_of_set < 2) ? 1 : $clog2(data_of_set);
  endfunction

endpackage : ring_buffer_pkg
`default_nettype wire

// File: rtl/ring_buffer_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : ring_buffer_reader_if
// Description : Bundles the ring-buffer read port and the PE-side streaming
//               handshake of the ring buffer reader.
//   empty_flag : ring buffer empty indication          (to reader)
//   ren        : ring buffer read enable               (from reader)
//   buf_dout   : ring buffer read data, next cycle     (to reader)
//   flush      : synchronous abort                     (to reader)
//   out_valid / out_ready / out_data / out_lane / out_last : lane stream
//   sets_done  : count of fully transferred sets       (from reader)
//   Modports: master = reader side, slave = buffer / PE / control side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ring_buffer_reader_if #(
  parameter int DATA_WIDTH  = ring_buffer_pkg::DEF_DATA_WIDTH,
  parameter int DATA_OF_SET = ring_buffer_pkg::DEF_DATA_OF_SET,
  parameter int CNT_WIDTH   = 16
);
  import ring_buffer_pkg::*;

  localparam int LANE_W = lane_width(DATA_OF_SET);

  logic                                    empty_flag;
  logic                                    ren;
  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]  buf_dout;
  logic                                    flush;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [DATA_WIDTH-1:0]                   out_data;
  logic [LANE_W-1:0]                       out_lane;
  logic                                    out_last;
  logic [CNT_WIDTH-1:0]                    sets_done;

  modport master (
    input  empty_flag, buf_dout, flush, out_ready,
    output ren, out_valid, out_data, out_lane, out_last, sets_done
  );

  modport slave (
    output empty_flag, buf_dout, flush, out_ready,
    input  ren, out_valid, out_data, out_lane, out_last, sets_done
  );

endinterface : ring_buffer_reader_if
`default_nettype wire

// File: rtl/ring_buffer_reader_set_serializer.sv
`default_nettype none
// ============================================================================
// Module      : set_serializer
// Description : Holds one set of DATA_OF_SET words and presents it one lane
//               at a time, lane 0 first.
//   clk, rst   : clock, asynchronous active-low reset
//   load       : capture din, restart at lane 0
//   advance    : step to the next lane (wraps to 0 after the last lane)
//   clear      : drop the held set and restart at lane 0 (wins over load)
//   din        : set to capture
//   valid      : outputs are forced to 0 while low
//   out_data / out_lane / out_last : current lane word, index, last flag
// Revision    : 1.0 - initial release
// ============================================================================
module set_serializer
  import ring_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DATA_OF_SET = DEF_DATA_OF_SET,
  parameter int LANE_W      = lane_width(DATA_OF_SET)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   load,
  input  logic                                   advance,
  input  logic                                   clear,
  input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] din,
  input  logic                                   valid,
  output logic [DATA_WIDTH-1:0]                  out_data,
  output logic [LANE_W-1:0]                      out_lane,
  output logic                                   out_last
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(DATA_OF_SET - 1);

  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
  logic [LANE_W-1:0]                      lane_q, lane_d;
  logic                                   at_last;

  assign at_last = (lane_q == LAST_LANE);

  always_comb begin
    hold_d = hold_q;
    lane_d = lane_q;
    if (clear) begin
      hold_d = '0;
      lane_d = '0;
    end else if (load) begin
      hold_d = din;
      lane_d = '0;
    end else if (advance) begin
      // Explicit wrap so non-power-of-two set sizes never index past the set.
      lane_d = at_last ? '0 : lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      lane_q <= '0;
    end else begin
      hold_q <= hold_d;
      lane_q <= lane_d;
    end
  end

  // Outputs read as zero whenever nothing is being offered downstream.
  always_comb begin
    out_data = '0;
    out_lane = '0;
    out_last = 1'b0;
    if (valid) begin
      out_data = hold_q[lane_q];
      out_lane = lane_q;
      out_last = at_last;
    end
  end

endmodule : set_serializer
`default_nettype wire

// File: rtl/ring_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : ring_buffer_reader
// Description : Read-side consumer of the convolution input ring buffer.
//               Pops one set whenever the buffer is non-empty, holds it and
//               streams it lane by lane to the PE datapath (valid/ready).
//   clk        : clock
//   rst        : asynchronous reset, active low
//   bus        : ring_buffer_reader_if.master (ren/empty_flag/buf_dout,
//                flush, out_* stream, sets_done)
//   Optional   : `define READER_PREFETCH_EN to issue the next read on the
//                last-lane handshake and skip the IDLE cycle between sets.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_buffer_reader
  import ring_buffer_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DATA_OF_SET = DEF_DATA_OF_SET,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ring_buffer_reader_if.master  bus
);

  localparam int LANE_W = lane_width(DATA_OF_SET);

  localparam logic [1:0] ST_IDLE = RS_IDLE;
  localparam logic [1:0] ST_WAIT = RS_WAIT;
  localparam logic [1:0] ST_SEND = RS_SEND;

  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ren;
  logic                   out_valid;
  logic                   handshake;
  logic                   ser_load;
  logic                   ser_advance;
  logic                   ser_clear;
  logic [DATA_WIDTH-1:0]  ser_data;
  logic [LANE_W-1:0]      ser_lane;
  logic                   ser_last;

  assign out_valid = (state_q == ST_SEND);
  assign handshake = out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ren         = 1'b0;
    ser_load    = 1'b0;
    ser_advance = 1'b0;
    ser_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ren = !bus.empty_flag;
        if (ren) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // The set read in the previous cycle is on buf_dout now.
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end

      ST_SEND: begin
        if (handshake) begin
          ser_advance = 1'b1;
          if (ser_last) begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = ST_IDLE;
`ifdef READER_PREFETCH_EN
            if (!bus.empty_flag) begin
              ren     = 1'b1;
              state_d = ST_WAIT;
            end
`endif
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything: no read, no credit for a coinciding
    // last-lane handshake, and any set in flight (or arriving) is dropped.
    if (bus.flush) begin
      state_d     = ST_IDLE;
      cnt_d       = cnt_q;
      ren         = 1'b0;
      ser_load    = 1'b0;
      ser_advance = 1'b0;
      ser_clear   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  set_serializer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_OF_SET (DATA_OF_SET),
    .LANE_W      (LANE_W)
  ) u_set_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .advance  (ser_advance),
    .clear    (ser_clear),
    .din      (bus.buf_dout),
    .valid    (out_valid),
    .out_data (ser_data),
    .out_lane (ser_lane),
    .out_last (ser_last)
  );

  assign bus.ren       = ren;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = ser_data;
  assign bus.out_lane  = ser_lane;
  assign bus.out_last  = ser_last;
  assign bus.sets_done = cnt_q;

endmodule : ring_buffer_reader
`default_nettype wire
